freq_bcd_conv: RTL
==================

Name: freq_bcd_conv

Overview:
- Downstream stage of the theoretical-frequency calculator.
- Takes the 32-bit binary frequency value (Hz) and converts it to packed BCD for the seven-segment display driver, using a sequential shift-add-3 (double-dabble) engine on clk_100kHz, one bit per cycle.
- Conversion starts automatically whenever the input value differs from the last value converted.
- Results above the display range saturate and raise an overflow flag.

Parameters:
- IN_W, 32: binary input width.
- DIGITS, 8: number of BCD digits presented on bcd_out.
- The internal BCD register holds enough digits for 2^IN_W-1 (10 digits at IN_W=32).

Ports:
- clk_100kHz  input  1  system clock, 100 kHz.
- rst_  input  1  reset, asynchronous, active-low.
- freq_in  input  IN_W  binary frequency value in Hz, from the frequency calculator; may change on any cycle.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 in [3:0]; registered, held between conversions.
- ovf  output  1  high when the last converted value exceeded 10^DIGITS-1; updated together with bcd_out.
- valid  output  1  one-cycle pulse in the cycle after bcd_out/ovf update.
- busy  output  1  high while a conversion is in progress (CONV and DONE).

Behaviour:
- Reset (async, rst_=0) clears:
  - bcd_out=0, ovf=0, valid=0, busy=0;
  - last_val=0, shift/BCD registers=0, bit counter=0;
  - state=IDLE.
  - No conversion is forced after reset: 0 is already consistent with bcd_out=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - Each edge, compare freq_in with last_val.
  - If they differ: latch freq_in into bin_sr and into last_val; clear the BCD register; counter=0; ovf_pend=(freq_in > 10^DIGITS-1); busy<=1; go to CONV.
  - Otherwise stay in IDLE. valid=0.
- CONV, each edge:
  - Every BCD nibble >=5 gets +3 (combinational, all nibbles in parallel).
  - Then {bcd, bin_sr} shifts left by 1.
  - Counter increments.
  - After the IN_W-th shift (counter==IN_W-1 on that edge), go to DONE.
  - Exactly IN_W shift cycles per conversion.
- DONE, one edge:
  - bcd_out <= low DIGITS digits of the BCD register, or all nibbles 4'h9 if ovf_pend.
  - ovf <= ovf_pend; valid <= 1 for one cycle; busy <= 0; go to IDLE.
- Latency: from the IDLE edge that samples a new freq_in to the bcd_out update is IN_W+1 edges (33 at default); valid is high for the following cycle. The earliest next conversion starts on the edge after DONE.
- Input changes during CONV/DONE are ignored; the in-flight conversion completes with the latched value. On return to IDLE, freq_in is compared against last_val, so the latest value is converted next and intermediate values are dropped.
- Input returning to last_val before IDLE triggers no extra conversion.
- No arithmetic wrap: the BCD register is wide enough for the full IN_W range; saturation is applied only at output.
- Reset asserted mid-conversion aborts immediately: all values return to reset state. The next conversion occurs only if freq_in != 0 after release.
- bcd_out never shows partial results; it changes only in DONE.

Test Plan:
- freq_in 0 -> 99609 (freq_ctrl=255) -> busy high 33 cycles, bcd_out=32'h0009_9609, ovf=0, single valid pulse.
- freq_in=390 (freq_ctrl=1) held 200 cycles -> exactly one conversion, bcd_out=32'h0000_0390, one valid pulse total.
- freq_in 99609 -> 0 -> conversion runs, bcd_out=32'h0000_0000, valid pulses.
- freq_in=100_000_000 -> bcd_out=32'h9999_9999, ovf=1. Then freq_in=99_999_999 -> bcd_out=32'h9999_9999, ovf=0.
- Change freq_in 1000 -> 2000 at shift cycle 10 -> first result 32'h0000_1000, valid; second conversion starts next cycle, result 32'h0000_2000.
- Assert rst_ at shift cycle 15 of converting 12345 -> outputs 0 immediately. Release with freq_in=12345 -> fresh conversion, bcd_out=32'h0001_2345 after 33 cycles.

Source files
------------

// File: rtl/freq_bcd_conv.sv
// freq_bcd_conv: binary Hz value to packed BCD for the 7-seg driver.
// Serial double-dabble, one bit per clk_100kHz cycle, saturating output.
module freq_bcd_conv #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk_100kHz,
  input  logic                  rst_,
  input  logic [IN_W-1:0]       freq_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  valid,
  output logic                  busy
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  // digits needed for 2^IN_W-1 (log10(2) ~ 0.30103)
  localparam int NEED  = (IN_W * 30103) / 100000 + 1;
  localparam int BCD_N = (NEED > DIGITS) ? NEED : DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     last_q, last_d;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovfp_q, ovfp_d;
  logic [4*DIGITS-1:0] out_q, out_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [BCD_W-1:0]      adj;
  logic [BCD_W+IN_W-1:0] sh;

  // state and datapath registers
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      last_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // add-3 on every nibble >= 5, then shift {bcd, bin} left one bit
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin_q} << 1;
  end

  // next-state and output decode
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (freq_in != last_q) begin
          bin_d   = freq_in;
          last_d  = freq_in;
          bcd_d   = '0;
          cnt_d   = '0;
          ovfp_d  = 64'(freq_in) > LIMIT;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = sh[BCD_W+IN_W-1:IN_W];
        bin_d = sh[IN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_W - 1))
          state_d = DONE;
      end
      DONE: begin
        out_d   = ovfp_q ? {DIGITS{4'h9}}
                         : bcd_q[4*DIGITS-1:0];
        ovf_d   = ovfp_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd_out = out_q;
  assign ovf     = ovf_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule
